// File: rtl/qr_pkg.sv
// Shared types and constants for the finder-pattern scan pipeline.
// Run history entries, FSM states and ratio arithmetic helpers.
package qr_pkg;

  typedef enum logic {
    ROW_SCAN,
    COL_SCAN
  } scan_dir_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } scan_state_t;

  localparam int FRAME_W = 480;
  localparam int FRAME_H = 480;

  localparam int RATIO_DEN  = 14;
  localparam int SIDE_MAX   = 3;
  localparam int CENTRE_MIN = 5;
  localparam int CENTRE_MAX = 7;

  typedef struct packed {
    logic [8:0] len;
    logic [8:0] start;
    logic       colour;
  } run_t;

  // index 0 is the oldest run (r0), index 4 the newest (r4)
  typedef run_t [4:0] hist_t;

  typedef struct packed {
    logic       valid;
    logic       eol;
    logic [8:0] pos;
  } pix_tag_t;

  function automatic hist_t hist_push(
    input hist_t h,
    input run_t  r
  );
    return {r, h[4:1]};
  endfunction

  function automatic logic [8:0] len_inc(
    input logic [8:0] len
  );
    return (len == 9'd511) ? len : len + 9'd1;
  endfunction

  function automatic logic [15:0] mul16(
    input logic [11:0] v,
    input int          k
  );
    return 16'(v) * 16'(k);
  endfunction

endpackage

// File: rtl/finder_ratio_check.sv
// Registered 1:1:3:1:1 ratio test over a five-run window.
// Produces the match flag and centre index one cycle after push.
module finder_ratio_check
  import qr_pkg::*;
(
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            push,
  input  logic [4:0][8:0] run_len,
  input  logic [4:0]      run_col,
  input  logic [8:0]      centre_start,
  output logic            match,
  output logic [8:0]      centre
);

  logic [11:0] total;
  logic [15:0] t1;
  logic [15:0] t3;
  logic [15:0] t5;
  logic [15:0] t7;
  logic [15:0] scaled [5];
  logic        side_ok;
  logic        centre_ok;
  logic        colour_ok;

  always_comb begin
    total = '0;
    for (int i = 0; i < 5; i++) begin
      total = total + 12'(run_len[i]);
    end
    t1 = 16'(total);
    t3 = mul16(total, SIDE_MAX);
    t5 = mul16(total, CENTRE_MIN);
    t7 = mul16(total, CENTRE_MAX);
    for (int i = 0; i < 5; i++) begin
      scaled[i] = mul16(12'(run_len[i]), RATIO_DEN);
    end
    side_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i != 2) begin
        side_ok = side_ok
          & (scaled[i] >= t1)
          & (scaled[i] <= t3);
      end
    end
    centre_ok = (scaled[2] >= t5)
      && (scaled[2] <= t7);
    // B,W,B,W,B with r0 in bit 0
    colour_ok = (run_col == 5'b01010);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      match  <= 1'b0;
      centre <= '0;
    end else begin
      match  <= push & colour_ok
        & side_ok & centre_ok;
      centre <= centre_start
        + (run_len[2] >> 1);
    end
  end

endmodule

// File: rtl/finder_line_scan.sv
// Streams a frame line by line, run-length encodes it and marks
// scan-axis positions whose runs form a 1:1:3:1:1 finder profile.
module finder_line_scan
  import qr_pkg::*;
#(
  parameter int HEIGHT       = FRAME_H,
  parameter int WIDTH        = FRAME_W,
  parameter int DIRECTION    = 0,
  parameter int READ_LATENCY = 2
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         start_scan,
  input  logic         pixel_reading,
  output logic [19:0]  address_reading,
  output logic [479:0] patterns,
  output logic         patterns_valid,
  output logic         busy
);

  localparam scan_dir_t DIR =
    (DIRECTION == 1) ? COL_SCAN : ROW_SCAN;
  localparam int PLEN =
    (DIR == COL_SCAN) ? HEIGHT : WIDTH;
  localparam int NLINES =
    (DIR == COL_SCAN) ? WIDTH : HEIGHT;
  localparam logic [8:0] POS_LAST = 9'(PLEN - 1);
  localparam logic [8:0] LINE_LAST = 9'(NLINES - 1);
  localparam logic [19:0] STEP =
    (DIR == COL_SCAN) ? 20'(WIDTH) : 20'd1;

  scan_state_t state_q;
  scan_state_t state_d;

  logic       issue;
  logic       start_acc;
  logic       last_addr;
  logic       tags_busy;
  logic [8:0] pos_q;
  logic [8:0] line_q;

  pix_tag_t tag_in;
  pix_tag_t tag_q [READ_LATENCY];
  pix_tag_t px;

  logic [8:0] cur_len_q;
  logic [8:0] cur_start_q;
  logic       cur_col_q;
  hist_t      hist_q;

  logic  chg;
  logic  eol;
  logic  push;
  run_t  cur_run;
  run_t  live_run;
  hist_t win1;
  hist_t win2;
  hist_t eval_win;

  logic [4:0][8:0] eval_len;
  logic [4:0]      eval_col;
  logic            match;
  logic [8:0]      centre;
  logic            unused_start_bits;

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_scan) state_d = SCAN;
      SCAN:    if (last_addr) state_d = DRAIN;
      // eval stage commits on the same edge DONE is entered
      DRAIN:   if (!tags_busy) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    issue          = (state_q == SCAN);
    start_acc      = (state_q == IDLE) && start_scan;
    busy           = (state_q == SCAN)
      || (state_q == DRAIN);
    patterns_valid = (state_q == DONE);
  end

  assign last_addr = (pos_q == POS_LAST)
    && (line_q == LINE_LAST);

  always_ff @(posedge clk_in) begin
    if (rst_in || start_acc) begin
      pos_q           <= '0;
      line_q          <= '0;
      address_reading <= '0;
    end else if (issue && !last_addr) begin
      if (pos_q == POS_LAST) begin
        pos_q  <= '0;
        line_q <= line_q + 9'd1;
        address_reading <= (DIR == COL_SCAN)
          ? 20'(line_q) + 20'd1
          : address_reading + 20'd1;
      end else begin
        pos_q           <= pos_q + 9'd1;
        address_reading <= address_reading + STEP;
      end
    end
  end

  always_comb begin
    tag_in = '{
      valid: issue,
      eol:   (pos_q == POS_LAST),
      pos:   pos_q
    };
    tags_busy = 1'b0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      tags_busy = tags_busy | tag_q[i].valid;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  always_comb begin
    px  = tag_q[READ_LATENCY-1];
    eol = px.valid && px.eol;
    chg = px.valid && (cur_len_q != '0)
      && (pixel_reading != cur_col_q);
    cur_run = '{
      len:    cur_len_q,
      start:  cur_start_q,
      colour: cur_col_q
    };
    if (chg || (cur_len_q == '0)) begin
      live_run = '{
        len:    9'd1,
        start:  px.pos,
        colour: pixel_reading
      };
    end else begin
      live_run = '{
        len:    len_inc(cur_len_q),
        start:  cur_start_q,
        colour: cur_col_q
      };
    end
    win1 = chg ? hist_push(hist_q, cur_run) : hist_q;
    win2 = hist_push(win1, live_run);
    // at most one of the two line-end pushes ends on black
    eval_win = (eol && !(chg && !cur_col_q))
      ? win2 : win1;
    push = chg || eol;
    for (int i = 0; i < 5; i++) begin
      eval_len[i] = eval_win[i].len;
      eval_col[i] = eval_win[i].colour;
    end
  end

  assign unused_start_bits = ^{
    eval_win[0].start, eval_win[1].start,
    eval_win[3].start, eval_win[4].start
  };

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hist_q      <= '0;
      cur_len_q   <= '0;
      cur_start_q <= '0;
      cur_col_q   <= 1'b0;
    end else if (px.valid) begin
      if (px.eol) begin
        hist_q      <= '0;
        cur_len_q   <= '0;
        cur_start_q <= '0;
        cur_col_q   <= 1'b0;
      end else begin
        hist_q      <= win1;
        cur_len_q   <= live_run.len;
        cur_start_q <= live_run.start;
        cur_col_q   <= live_run.colour;
      end
    end
  end

  finder_ratio_check u_ratio (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .push         (push),
    .run_len      (eval_len),
    .run_col      (eval_col),
    .centre_start (eval_win[2].start),
    .match        (match),
    .centre       (centre)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in || start_acc) begin
      patterns <= '0;
    end else if (match) begin
      patterns[centre] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_finder_line_scan.sv
// Scoreboard bench: row-scan and column-scan instances see the same
// logical image; a run-list reference model predicts the patterns.
module tb_finder_line_scan;

  localparam int NL = 12;
  localparam int NP = 128;
  localparam int N  = NL * NP;

  typedef struct {
    logic [479:0] pat;
    int           s;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         start;
  logic [19:0]  addr [2];
  logic [479:0] pats [2];
  logic         pv   [2];
  logic         bz   [2];

  bit   img [NL][NP];
  exp_t sb_q [2][$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(
    input string        name,
    input logic [479:0] act,
    input logic [479:0] req
  );
    compared++;
    if (act !== req) begin
      mismatched++;
      if (mismatched <= 40)
        $display("FAIL %s: got %0h required %0h",
          name, act, req);
    end
  endtask

  function automatic logic pix_at(
    input int          g,
    input logic [19:0] a
  );
    int l;
    int p;
    if (g == 0) begin
      l = int'(a) / NP;
      p = int'(a) % NP;
    end else begin
      l = int'(a) % NL;
      p = int'(a) / NL;
    end
    if (l < NL && p < NP) return img[l][p];
    return 1'b1;
  endfunction

  function automatic int exp_addr(
    input int g,
    input int idx
  );
    if (g == 0) return idx;
    return (idx / NP) + (idx % NP) * NL;
  endfunction

  // one run list per line, every 5-run window judged on its own
  function automatic logic [479:0] ref_model();
    logic [479:0] r;
    r = '0;
    for (int l = 0; l < NL; l++) begin
      int rc [NP];
      int rl [NP];
      int rs [NP];
      int nr;
      nr = 0;
      for (int p = 0; p < NP; p++) begin
        if (p == 0 || img[l][p] != img[l][p-1]) begin
          rc[nr] = int'(img[l][p]);
          rl[nr] = 1;
          rs[nr] = p;
          nr++;
        end else begin
          rl[nr-1]++;
        end
      end
      for (int j = 4; j < nr; j++) begin
        int t;
        bit ok;
        t = rl[j-4] + rl[j-3] + rl[j-2]
          + rl[j-1] + rl[j];
        ok = rc[j-4] == 0 && rc[j-3] == 1
          && rc[j-2] == 0 && rc[j-1] == 1
          && rc[j] == 0;
        for (int k = 0; k < 5; k++) begin
          if (k != 2)
            ok = ok && (14 * rl[j-4+k] >= t)
              && (14 * rl[j-4+k] <= 3 * t);
        end
        ok = ok && (5 * t <= 14 * rl[j-2])
          && (14 * rl[j-2] <= 7 * t);
        if (ok) r[rs[j-2] + rl[j-2] / 2] = 1'b1;
      end
    end
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int W = (g == 1) ? NL : NP;
    localparam int H = (g == 1) ? NP : NL;
    logic q1;
    logic q2;
    int   idx;

    finder_line_scan #(
      .HEIGHT       (H),
      .WIDTH        (W),
      .DIRECTION    (g),
      .READ_LATENCY (2)
    ) u_dut (
      .clk_in          (clk),
      .rst_in          (rst),
      .start_scan      (start),
      .pixel_reading   (q2),
      .address_reading (addr[g]),
      .patterns        (pats[g]),
      .patterns_valid  (pv[g]),
      .busy            (bz[g])
    );

    always @(posedge clk) begin
      q1 <= pix_at(g, addr[g]);
      q2 <= q1;
    end

    always @(negedge clk) begin
      if (sb_q[g].size() != 0) begin
        idx = cyc - sb_q[g][0].s;
        if (idx < N)
          check("address", 480'(addr[g]),
            480'(exp_addr(g, idx)));
        if (idx <= N + 3)
          check("busy", 480'(bz[g]),
            480'(idx <= N + 2));
        if (pv[g]) begin
          check("valid_cycle", 480'(idx), 480'(N + 3));
          check("patterns", pats[g], sb_q[g][0].pat);
          void'(sb_q[g].pop_front());
        end else if (idx > N + 3) begin
          check("valid_timeout", 480'(pv[g]), 480'(1));
          void'(sb_q[g].pop_front());
        end
      end else begin
        check("idle_valid", 480'(pv[g]), 480'(0));
        check("idle_busy", 480'(bz[g]), 480'(0));
      end
    end
  end

  task automatic fill(input bit v);
    foreach (img[l, p]) img[l][p] = v;
  endtask

  task automatic put(
    input int l, input int p, input bit c, input int n
  );
    for (int i = 0; i < n && p + i < NP; i++)
      img[l][p+i] = c;
  endtask

  task automatic put5(
    input int l, input int p0,
    input int a, input int b, input int c,
    input int d, input int e
  );
    int p;
    p = p0;
    put(l, p, 1'b0, a); p += a;
    put(l, p, 1'b1, b); p += b;
    put(l, p, 1'b0, c); p += c;
    put(l, p, 1'b1, d); p += d;
    put(l, p, 1'b0, e);
  endtask

  task automatic rand_image();
    for (int l = 0; l < NL; l++) begin
      int p;
      bit c;
      p = 0;
      c = 1'($urandom_range(0, 1));
      while (p < NP) begin
        if ($urandom_range(0, 4) == 0) begin
          int u;
          u = int'($urandom_range(1, 6));
          for (int k = 0; k < 5; k++) begin
            int n;
            n = ((k == 2) ? 3 * u : u)
              + int'($urandom_range(0, 1));
            put(l, p, (k % 2) == 1, n);
            p += n;
          end
          c = 1'b1;
        end else begin
          int n;
          n = int'($urandom_range(1, 12));
          put(l, p, c, n);
          p += n;
          c = ~c;
        end
      end
    end
  endtask

  task automatic launch();
    exp_t ex;
    ex.pat = ref_model();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    ex.s = cyc;
    sb_q[0].push_back(ex);
    sb_q[1].push_back(ex);
  endtask

  task automatic do_scan(input bit poke);
    launch();
    if (poke) begin
      repeat (500) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    for (int i = 0; i < N + 20; i++) begin
      if (sb_q[0].size() == 0 && sb_q[1].size() == 0)
        break;
      @(posedge clk);
    end
    #1;
    if (sb_q[0].size() != 0 || sb_q[1].size() != 0) begin
      check("scan_done", 480'(1), 480'(0));
      sb_q[0].delete();
      sb_q[1].delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state();
    for (int g = 0; g < 2; g++) begin
      check("rst_addr", 480'(addr[g]), 480'(0));
      check("rst_patterns", pats[g], 480'(0));
      check("rst_valid", 480'(pv[g]), 480'(0));
      check("rst_busy", 480'(bz[g]), 480'(0));
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    fill(1'b1);
    repeat (3) @(posedge clk);
    #1;
    check_reset_state();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    do_scan(1'b0);

    fill(1'b1);
    put5(3, 50, 10, 10, 30, 10, 10);
    do_scan(1'b0);

    fill(1'b1);
    put5(3, 50, 10, 10, 20, 10, 10);
    do_scan(1'b0);

    fill(1'b1);
    put5(3, 50, 10, 10, 35, 10, 10);
    do_scan(1'b0);

    fill(1'b1);
    put(5, 78, 1'b0, 10);
    put(5, 98, 1'b0, 30);
    put(6, 10, 1'b0, 10);
    do_scan(1'b0);

    fill(1'b1);
    put5(0, 0, 4, 4, 12, 4, 4);
    put5(11, 93, 5, 5, 15, 5, 5);
    do_scan(1'b1);

    for (int i = 0; i < 6; i++) begin
      rand_image();
      do_scan(1'b0);
    end

    rand_image();
    launch();
    repeat (1000) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    sb_q[0].delete();
    sb_q[1].delete();
    rst = 1'b0;
    check_reset_state();
    repeat (20) @(posedge clk);
    #1;
    do_scan(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      compared, mismatched);
    $finish;
  end

endmodule
